mio_imem: RTL

Instruction-memory responder for the `mio_*` fetch interface: the far end of the fetch stage's memory port. It accepts word-aligned fetch addresses, queues them, reads a synchronous word array, and returns `mio_vld`/`mio_rdata` strictly in request order. It also provides a load port that lets the testbench or boot logic fill program memory. It sits between the pipeline's fetch unit and instruction storage.

---
 rtl/mio_pkg.sv | 28 ++
 rtl/mio_req_fifo.sv | 57 +++++
 rtl/mio_imem.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mio_pkg.sv
// Shared types and constants for the mio_* instruction-fetch interface.
package mio_pkg;

  localparam int unsigned MIO_AW = 32;
  localparam int unsigned MIO_DW = 32;
  localparam logic [MIO_DW-1:0] MIO_ERR_DATA = 32'h0;

  // Wait-generator LFSR seed, loaded on clr.
  localparam logic [15:0] MIO_LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic [MIO_AW-1:0] addr;
  } mio_req_t;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [MIO_DW-1:0] rdata;
  } mio_rsp_t;

  // A fetch is bad when misaligned or beyond the 2^addr_bits-word array.
  function automatic logic mio_addr_err(logic [MIO_AW-1:0] addr, int unsigned addr_bits);
    logic [MIO_AW-1:0] upper;
    upper = addr >> (addr_bits + 2);
    return (addr[1:0] != 2'b00) || (upper != '0);
  endfunction

endpackage

// File: rtl/mio_req_fifo.sv
// Request FIFO for mio_imem: DEPTH entries of mio_req_t, synchronous clr flush.
module mio_req_fifo
  import mio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  mio_req_t                 din,
  output mio_req_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  mio_req_t            mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     cnt_q;
  logic                do_push;
  logic                do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally; count tracks push/pop, unchanged when both occur.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage needs no reset; only valid slots are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mio_imem.sv
// Instruction-memory responder: queued in-order fetches from a synchronous word array,
// plus a load port. Define MIO_IMEM_WAIT_EN to insert pseudo-random pre-pop wait cycles.
module mio_imem
  import mio_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 mio_req,
  input  logic [MIO_AW-1:0]    mio_addr,
  output logic                 mio_rdy,
  output logic                 mio_vld,
  output logic [MIO_DW-1:0]    mio_rdata,
  output logic                 mio_err,
  input  logic                 ld_we,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [MIO_DW-1:0]    ld_data
);

  localparam int unsigned Words = 2 ** ADDR_BITS;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  logic [MIO_DW-1:0]    mem_q [Words];
  logic [MIO_DW-1:0]    rd_data_q;
  logic                 vld_q;
  logic                 err_q;
  mio_req_t             push_req;
  mio_req_t             head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CntW-1:0]      fifo_count;
  logic                 accept;
  logic                 issue;
  logic                 head_err;
  logic [ADDR_BITS-1:0] head_word;
  logic                 wait_zero;
  mio_rsp_t             rsp;

  assign push_req.addr = mio_addr;
  // Ready comes from the registered count, so a same-cycle pop cannot raise it.
  assign mio_rdy   = (fifo_count != CntW'(DEPTH));
  assign accept    = mio_req & ~fifo_full;
  assign issue     = ~fifo_empty & wait_zero;
  assign head_err  = mio_addr_err(head.addr, ADDR_BITS);
  assign head_word = head.addr[ADDR_BITS+1:2];

  mio_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (accept),
    .pop   (issue),
    .din   (push_req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef MIO_IMEM_WAIT_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [15:0] lfsr_next;
  logic [1:0]  wait_q;
  logic [1:0]  wait_d;

  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign wait_zero = (wait_q == 2'd0);

  // Each pop advances the LFSR and arms the wait before the next pop;
  // the wait only counts down while a request is pending.
  always_comb begin
    lfsr_d = lfsr_q;
    wait_d = wait_q;
    if (issue) begin
      lfsr_d = lfsr_next;
      wait_d = lfsr_next[1:0];
    end else if (!fifo_empty && (wait_q != 2'd0)) begin
      wait_d = wait_q - 2'd1;
    end
  end

  // Wait generator state.
  always_ff @(posedge clk) begin
    if (clr) begin
      lfsr_q <= MIO_LFSR_SEED;
      wait_q <= MIO_LFSR_SEED[1:0];
    end else begin
      lfsr_q <= lfsr_d;
      wait_q <= wait_d;
    end
  end
`else
  assign wait_zero = 1'b1;
`endif

  // Word array: load-port write and issue read share an edge, so the read sees old data.
  always_ff @(posedge clk) begin
    if (ld_we) mem_q[ld_addr] <= ld_data;
    if (issue && !head_err) rd_data_q <= mem_q[head_word];
  end

  // Response qualifiers; clr drops any read issued in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vld_q <= issue;
      err_q <= issue & head_err;
    end
  end

  // Response assembly: rdata is forced to zero when idle or on error.
  always_comb begin
    rsp       = '0;
    rsp.vld   = vld_q;
    rsp.err   = err_q;
    if (vld_q) rsp.rdata = err_q ? MIO_ERR_DATA : rd_data_q;
  end

  assign mio_vld   = rsp.vld;
  assign mio_err   = rsp.err;
  assign mio_rdata = rsp.rdata;

endmodule
